// File: rtl/de_stage.sv
// Decode stage: IF/ID register, MIPS-subset decode, ID/EX register and
// load-use hazard detection driving the fetch stall code on ctr.
module de_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_npc,
   input  logic [31:0] in_isn,
   input  logic        flush,
   output logic [1:0]  ctr,
   output logic        out_valid,
   output logic [31:0] out_npc,
   output logic [4:0]  out_rs,
   output logic [4:0]  out_rt,
   output logic [4:0]  out_dst,
   output logic [31:0] out_imm,
   output logic [25:0] out_jtarget,
   output logic [2:0]  out_alu_op,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        out_branch,
   output logic        out_jump,
   output logic        out_illegal
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100
   } alu_op_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] npc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dst;
      logic [31:0] imm;
      logic [25:0] jtarget;
      alu_op_e     alu_op;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        illegal;
   } idex_t;

   // An invalid slot never carries control flags, so bubbles and killed
   // instructions are harmless downstream.
   function automatic idex_t kill(input idex_t x);
      idex_t r;
      r           = x;
      r.valid     = 1'b0;
      r.reg_write = 1'b0;
      r.mem_read  = 1'b0;
      r.mem_write = 1'b0;
      r.branch    = 1'b0;
      r.jump      = 1'b0;
      r.illegal   = 1'b0;
      return r;
   endfunction

   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] ifid_npc_q, ifid_npc_d;
   logic [31:0] ifid_isn_q, ifid_isn_d;
   idex_t       idex_q, idex_d, dec;
   logic        uses_rs, uses_rt, hz, stall;
   logic [5:0]  opcode, funct;

   assign opcode = ifid_isn_q[31:26];
   assign funct  = ifid_isn_q[5:0];

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      dec         = '0;
      uses_rs     = 1'b0;
      uses_rt     = 1'b0;
      dec.valid   = ifid_valid_q;
      dec.npc     = ifid_npc_q;
      dec.rs      = ifid_isn_q[25:21];
      dec.rt      = ifid_isn_q[20:16];
      dec.imm     = {{16{ifid_isn_q[15]}}, ifid_isn_q[15:0]};
      dec.jtarget = ifid_isn_q[25:0];
      dec.alu_op  = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  dec.alu_op = ALU_ADD;
               FN_SUB:  dec.alu_op = ALU_SUB;
               FN_AND:  dec.alu_op = ALU_AND;
               FN_OR:   dec.alu_op = ALU_OR;
               FN_SLT:  dec.alu_op = ALU_SLT;
               default: dec.illegal = 1'b1;
            endcase
            if (!dec.illegal) begin
               dec.dst = ifid_isn_q[15:11];
               uses_rs = 1'b1;
               uses_rt = 1'b1;
            end
         end
         OP_ADDI: begin
            dec.dst = dec.rt;
            uses_rs = 1'b1;
         end
         OP_LW: begin
            dec.dst      = dec.rt;
            dec.mem_read = 1'b1;
            uses_rs      = 1'b1;
         end
         OP_SW: begin
            dec.mem_write = 1'b1;
            uses_rs       = 1'b1;
            uses_rt       = 1'b1;
         end
         OP_BEQ: begin
            dec.branch = 1'b1;
            dec.alu_op = ALU_SUB;
            uses_rs    = 1'b1;
            uses_rt    = 1'b1;
         end
         OP_J:    dec.jump    = 1'b1;
         default: dec.illegal = 1'b1;
      endcase
      dec.reg_write = (dec.dst != 5'd0);
      if (!ifid_valid_q) dec = kill(dec);
   end

   assign hz = ifid_valid_q & idex_q.valid & idex_q.mem_read & (idex_q.dst != 5'd0) &
               ((uses_rs & (dec.rs == idex_q.dst)) | (uses_rt & (dec.rt == idex_q.dst)));
   assign stall = hz & ~flush;
   assign ctr   = stall ? 2'b10 : 2'b00;

   always_comb begin
      ifid_valid_d = in_valid;
      ifid_npc_d   = in_npc;
      ifid_isn_d   = in_isn;
      if (stall) begin
         ifid_valid_d = ifid_valid_q;
         ifid_npc_d   = ifid_npc_q;
         ifid_isn_d   = ifid_isn_q;
      end
      if (flush) ifid_valid_d = 1'b0;
      idex_d = (hz | flush) ? kill(dec) : dec;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      if (rst) begin
         ifid_valid_q <= 1'b0;
         ifid_npc_q   <= '0;
         ifid_isn_q   <= '0;
         idex_q       <= '0;
      end else begin
         ifid_valid_q <= ifid_valid_d;
         ifid_npc_q   <= ifid_npc_d;
         ifid_isn_q   <= ifid_isn_d;
         idex_q       <= idex_d;
      end
   end

   assign out_valid     = idex_q.valid;
   assign out_npc       = idex_q.npc;
   assign out_rs        = idex_q.rs;
   assign out_rt        = idex_q.rt;
   assign out_dst       = idex_q.dst;
   assign out_imm       = idex_q.imm;
   assign out_jtarget   = idex_q.jtarget;
   assign out_alu_op    = idex_q.alu_op;
   assign out_reg_write = idex_q.reg_write;
   assign out_mem_read  = idex_q.mem_read;
   assign out_mem_write = idex_q.mem_write;
   assign out_branch    = idex_q.branch;
   assign out_jump      = idex_q.jump;
   assign out_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_de_stage.sv
// Scoreboard bench for de_stage: a fetch-like driver issues instructions,
// an independent monitor compares every emitted ID/EX slot against a reference decode.
module tb_de_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush;
   logic [31:0] in_npc, in_isn;
   logic [1:0]  ctr;
   logic        out_valid;
   logic [31:0] out_npc, out_imm;
   logic [4:0]  out_rs, out_rt, out_dst;
   logic [25:0] out_jtarget;
   logic [2:0]  out_alu_op;
   logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal;

   always #5 clk = ~clk;

   de_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_npc(in_npc), .in_isn(in_isn),
      .flush(flush), .ctr(ctr), .out_valid(out_valid), .out_npc(out_npc),
      .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst), .out_imm(out_imm),
      .out_jtarget(out_jtarget), .out_alu_op(out_alu_op), .out_reg_write(out_reg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_branch(out_branch),
      .out_jump(out_jump), .out_illegal(out_illegal)
   );

   typedef struct packed {
      logic [31:0] npc;
      logic [4:0]  rs, rt, dst;
      logic [31:0] imm;
      logic [25:0] jt;
      logic [2:0]  alu;
      logic        rw, mr, mw, br, jp, il;
   } exp_t;

   exp_t         sb_q[$];
   exp_t         dut_out, mon_e;
   logic [116:0] all_out;
   logic [5:0]   flags;
   int           n_tests = 0, n_fail = 0;
   int           obs_stalls = 0, exp_stalls = 0;
   bit           prev_v = 1'b0, mon_en = 1'b0;
   logic [31:0]  prev_isn = '0;

   assign dut_out = {out_npc, out_rs, out_rt, out_dst, out_imm, out_jtarget, out_alu_op,
                     out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal};
   assign flags   = {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal};
   assign all_out = {ctr, out_valid, dut_out};

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference decode written straight from the instruction table.
   function automatic exp_t ref_decode(input logic [31:0] npc, input logic [31:0] isn);
      exp_t e = '0;
      e.npc = npc;
      e.rs  = isn[25:21];
      e.rt  = isn[20:16];
      e.imm = {{16{isn[15]}}, isn[15:0]};
      e.jt  = isn[25:0];
      if (isn[31:26] == 6'h00) begin
         case (isn[5:0])
            6'h20: begin e.dst = isn[15:11]; e.alu = 3'd0; end
            6'h22: begin e.dst = isn[15:11]; e.alu = 3'd1; end
            6'h24: begin e.dst = isn[15:11]; e.alu = 3'd2; end
            6'h25: begin e.dst = isn[15:11]; e.alu = 3'd3; end
            6'h2A: begin e.dst = isn[15:11]; e.alu = 3'd4; end
            default: e.il = 1'b1;
         endcase
      end else if (isn[31:26] == 6'h08) e.dst = isn[20:16];
      else if (isn[31:26] == 6'h23) begin e.dst = isn[20:16]; e.mr = 1'b1; end
      else if (isn[31:26] == 6'h2B) e.mw = 1'b1;
      else if (isn[31:26] == 6'h04) begin e.br = 1'b1; e.alu = 3'd1; end
      else if (isn[31:26] == 6'h02) e.jp = 1'b1;
      else e.il = 1'b1;
      e.rw = (e.dst != 5'd0);
      return e;
   endfunction

   function automatic bit legal_r(input logic [31:0] isn);
      return isn[31:26] == 6'h00 && (isn[5:0] == 6'h20 || isn[5:0] == 6'h22 ||
             isn[5:0] == 6'h24 || isn[5:0] == 6'h25 || isn[5:0] == 6'h2A);
   endfunction

   function automatic bit reads_rs(input logic [31:0] isn);
      return legal_r(isn) || isn[31:26] == 6'h08 || isn[31:26] == 6'h23 ||
             isn[31:26] == 6'h2B || isn[31:26] == 6'h04;
   endfunction

   function automatic bit reads_rt(input logic [31:0] isn);
      return legal_r(isn) || isn[31:26] == 6'h2B || isn[31:26] == 6'h04;
   endfunction

   // A valid instruction right behind a load that writes a register it reads costs one stall.
   function automatic bit ld_use(input logic [31:0] p, input logic [31:0] c);
      if (p[31:26] != 6'h23 || p[20:16] == 5'd0) return 1'b0;
      return (reads_rs(c) && c[25:21] == p[20:16]) || (reads_rt(c) && c[20:16] == p[20:16]);
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid) begin
            if (sb_q.size() == 0) check("unexpected_output", 1, 0);
            else begin
               mon_e = sb_q.pop_front();
               check("decode", dut_out, mon_e);
            end
         end else begin
            check("bubble_flags_zero", flags, 0);
         end
      end
   end

   // Fetch-like driver: holds the word while ctr requests a stall.
   task automatic issue(input logic v, input logic [31:0] isn);
      int          waits = 0;
      logic [31:0] npc   = $urandom;
      @(negedge clk);
      in_valid = v; in_isn = isn; in_npc = npc;
      #1;
      while (ctr == 2'b10) begin
         obs_stalls++;
         waits++;
         if (waits > 3) begin
            check("stall_bound", waits, 3);
            break;
         end
         @(negedge clk);
         #1;
      end
      check("ctr_code", ctr, 2'b00);
      if (v) begin
         sb_q.push_back(ref_decode(npc, isn));
         if (prev_v && ld_use(prev_isn, isn)) exp_stalls++;
      end
      prev_v   = v;
      prev_isn = isn;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b0, $urandom);
   endtask

   task automatic wait_out();
      @(negedge clk);
      #2;
   endtask

   task automatic lw_add_pair();
      @(negedge clk);
      in_valid = 1'b1; in_isn = 32'h8C250004; in_npc = 32'h0000_0100;
      sb_q.push_back(ref_decode(32'h0000_0100, 32'h8C250004));
      @(negedge clk);
      in_isn = 32'h00A23020; in_npc = 32'h0000_0104;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      logic [4:0]  ra, rb, rc;
      rst = 1'b1; flush = 1'b0;
      in_valid = $urandom; in_npc = $urandom; in_isn = $urandom;
      @(negedge clk);
      in_valid = $urandom; in_npc = $urandom; in_isn = $urandom;
      @(negedge clk);
      #1;
      check("reset_outputs", all_out, 0);
      rst = 1'b0; in_valid = 1'b0;
      mon_en = 1'b1;

      issue(1'b1, 32'h00221820);
      issue(1'b0, $urandom);
      wait_out();
      check("rtype_fields", {out_valid, out_rs, out_rt, out_dst, out_alu_op, out_reg_write},
            {1'b1, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1});

      issue(1'b1, 32'h2004FFFF);
      issue(1'b0, $urandom);
      wait_out();
      check("addi_fields", {out_valid, out_imm, out_dst, out_reg_write},
            {1'b1, 32'hFFFF_FFFF, 5'd4, 1'b1});
      check("stalls_after_alu", obs_stalls, 0);

      issue(1'b1, 32'h8C250004);
      issue(1'b1, 32'h00A23020);
      issue(1'b0, $urandom);
      check("loaduse_one_stall", obs_stalls, 1);
      check("loaduse_bubble", out_valid, 0);
      wait_out();
      check("loaduse_add_out", {out_valid, out_dst}, {1'b1, 5'd6});
      check("loaduse_model_stalls", obs_stalls, exp_stalls);

      issue(1'b1, 32'h8C200004);
      issue(1'b1, 32'h00A23020);
      issue(1'b1, 32'h8C200004);
      issue(1'b1, 32'h00023020);
      idle(2);
      check("lw_r0_no_stall", obs_stalls, 1);

      issue(1'b1, 32'h8C250004);
      issue(1'b1, 32'h8CA70000);
      issue(1'b1, 32'h00E04020);
      idle(2);
      check("lw_chain_two_stalls", obs_stalls, 3);
      check("lw_chain_model", obs_stalls, exp_stalls);

      issue(1'b1, 32'hFC000000);
      issue(1'b0, $urandom);
      wait_out();
      check("illegal_flags", {out_valid, flags}, {1'b1, 6'b000001});
      check("illegal_no_stall", obs_stalls, 3);

      idle(3);
      lw_add_pair();
      check("flush_pre_stall", ctr, 2'b10);
      flush = 1'b1; in_isn = $urandom;
      #1;
      check("flush_ctr_run", ctr, 2'b00);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      check("flush_out_invalid0", out_valid, 0);
      @(negedge clk);
      #1;
      check("flush_out_invalid1", out_valid, 0);
      prev_v = 1'b0;

      idle(3);
      lw_add_pair();
      check("rst_pre_stall", ctr, 2'b10);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("rst_mid_stall", all_out, 0);
      rst = 1'b0; in_valid = 1'b0;
      prev_v = 1'b0;

      for (int i = 0; i < 300; i++) begin
         ra = 5'($urandom_range(0, 3));
         rb = 5'($urandom_range(0, 3));
         rc = 5'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0: w = {6'h00, ra, rb, rc, 5'd0, 6'h20};
            1: w = {6'h00, ra, rb, rc, 5'd0, 6'h22};
            2: w = {6'h00, ra, rb, rc, 5'd0, 6'h25};
            3: w = {6'h00, ra, rb, rc, 5'd0, 6'h2A};
            4: w = {6'h08, ra, rb, 16'($urandom)};
            5: w = {6'h23, ra, rb, 16'($urandom)};
            6: w = {6'h2B, ra, rb, 16'($urandom)};
            7: w = {6'h04, ra, rb, 16'($urandom)};
            8: w = {6'h02, 26'($urandom)};
            default: w = ($urandom_range(0, 1) != 0) ? {6'h3F, 26'($urandom)} :
                                                       {6'h00, ra, rb, rc, 5'd0, 6'h21};
         endcase
         issue($urandom_range(0, 4) != 0, w);
      end
      idle(4);
      check("scoreboard_drained", sb_q.size(), 0);
      check("random_stall_count", obs_stalls, exp_stalls);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/de_stage.md
# de_stage

Decode stage of the 5-stage in-order pipeline. Sits directly downstream of the fetch stage and consumes its instruction word and next-PC each cycle. Holds the IF/ID pipeline register, decodes the MIPS-subset instruction into fields and control flags, and registers the result into the ID/EX register. Detects load-use hazards and drives the fetch stage's 2-bit `ctr` input, with `2'b10` meaning stall.

## Interface
No parameters. Widths are fixed: 32-bit datapath, 5-bit register indices.

- `clk` in 1: single clock, posedge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: fetch output is a real instruction. Low for the first cycle after reset.
- `in_npc` in 32: next-PC from fetch, carried through unchanged.
- `in_isn` in 32: instruction word from fetch.
- `flush` in 1: branch/jump redirect from EX. Kills the instructions in IF/ID and ID/EX.
- `ctr` out 2: to fetch. `2'b10` = stall, `2'b00` = run. Other codes are never driven.
- `out_valid` out 1: ID/EX holds a real instruction.
- `out_npc` out 32: registered `in_npc`.
- `out_rs`, `out_rt` out 5: source register indices.
- `out_dst` out 5: destination register index. 0 if none.
- `out_imm` out 32: sign-extended `isn[15:0]`.
- `out_jtarget` out 26: `isn[25:0]`.
- `out_alu_op` out 3: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_branch`, `out_jump`, `out_illegal` out 1 each: control flags.

## Operation
- **IF/ID register** (`ifid_valid`, `ifid_npc`, `ifid_isn`): loads `in_*` each cycle unless a stall is active. Holds its contents while stalled.
- **Decode** (combinational, from IF/ID contents):
  - R-type (opcode 0x00) funct values: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Destination = rd. Uses rs and rt.
  - addi 0x08: destination = rt, alu add, uses rs.
  - lw 0x23: destination = rt, mem_read, alu add, uses rs.
  - sw 0x2B: mem_write, alu add, uses rs and rt.
  - beq 0x04: branch, alu sub, uses rs and rt.
  - j 0x02: jump. Uses no sources.
  - Any other opcode, or any other R-type funct: `illegal` = 1 and all other control flags 0. Valid is preserved.
  - `reg_write` = 1 when destination ≠ 0. Destination 0 forces `reg_write` = 0 and `out_dst` = 0.
- **Hazard:** `hz` = `ifid_valid` & `out_valid` & `out_mem_read` & (`out_dst` ≠ 0) & ((uses_rs & rs == `out_dst`) | (uses_rt & rt == `out_dst`)).
- **`ctr`** (combinational) = `2'b10` when `hz` & !`flush`, otherwise `2'b00`.
- **ID/EX register:**
  - On `hz`: loads a bubble (valid 0, all flags 0).
  - Otherwise: loads the decode of IF/ID, with `out_valid` = `ifid_valid`.
  - When valid is 0, all control flags are 0.
- **Flush:** has priority over stall. Clears `ifid_valid` and `out_valid` and all control flags at the next edge. `ctr` = `2'b00` during a flush.
- **Reset:** has priority over everything. All registers and outputs go to 0, including `ctr` = `2'b00` and `out_valid` = 0.

## Timing
- Decode latency is 1 cycle: IF/ID contents at edge N appear on `out_*` after edge N+1.
- A load-use hazard costs exactly one bubble:
  - `ctr` = `2'b10` for one cycle.
  - At the next edge, IF/ID holds and ID/EX takes the bubble.
  - The hazard then clears because `out_valid` = 0, and the dependent instruction issues one cycle later.
- Back-to-back lw → lw(dependent) → use: each pair stalls independently, one cycle each.
- Flush asserted in the same cycle as `hz`: no stall. Both registers are invalid at the next edge. IF/ID loads nothing valid (the fetch word is killed).
- `rst` asserted mid-stall: state clears at the next edge and `ctr` returns to `2'b00` combinationally once the registers clear.

## Test plan
- **Reset:** hold `rst` 2 cycles with random `in_*` → all outputs 0, `ctr` = `2'b00`.
- **R-type decode:** `in_isn` = 0x00221820 (add $3,$1,$2), valid → two edges later `out_rs`=1, `out_rt`=2, `out_dst`=3, `alu_op`=000, `reg_write`=1, `ctr` = `2'b00` throughout.
- **Immediate decode:** `in_isn` = 0x2004FFFF (addi $4,$0,-1) → `out_imm` = 0xFFFFFFFF, `out_dst`=4, `reg_write`=1.
- **Load-use:** 0x8C250004 (lw $5,4($1)) then 0x00A23020 (add $6,$5,$2) → `ctr` = `2'b10` for exactly one cycle, one bubble on `out_valid`, then the add appears with `out_dst`=6. The same sequence with lw to $0 (0x8C200004) → no stall.
- **Flush/stall collision:** create the load-use pair and assert `flush` in the stall cycle → `ctr` = `2'b00`, `out_valid` = 0 for the next two cycles, no stale add emitted.
- **Illegal:** `in_isn` = 0xFC000000 → `out_valid`=1, `out_illegal`=1, all other flags 0, no stall.
